// File: rtl/banco_registradores_varredura.sv
// Eight 8-bit registers plus a scan sequencer that steps the downstream 8:1 mux select.
// Optional synchronous clear of the bank is enabled by defining BANCO_CLR_EN.
module banco_registradores_varredura #(
    parameter int PRESCALE = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_en_i,
    input  logic [2:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic       scan_en_i,
    input  logic       hold_i,
`ifdef BANCO_CLR_EN
    input  logic       clr_i,
`endif
    output logic [7:0] d0_o,
    output logic [7:0] d1_o,
    output logic [7:0] d2_o,
    output logic [7:0] d3_o,
    output logic [7:0] d4_o,
    output logic [7:0] d5_o,
    output logic [7:0] d6_o,
    output logic [7:0] d7_o,
    output logic [2:0] sel_o,
    output logic       step_o,
    output logic       wrap_o,
    output logic       busy_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] TC = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        VARRENDO = 2'd1,
        PAUSADO  = 2'd2
    } estado_t;

    estado_t       estado_q;
    logic [PW-1:0] presc_q;
    logic [2:0]    sel_q;
    logic          step_q;
    logic          wrap_q;
    logic          busy_q;
    logic [7:0]    regs_q [8];
    logic [7:0]    regs_d [8];
    logic          clr_s;

`ifdef BANCO_CLR_EN
    assign clr_s = clr_i;
`else
    assign clr_s = 1'b0;
`endif

    // Next bank contents: clear beats a same-cycle write.
    always_comb begin
        regs_d = regs_q;
        if (clr_s) begin
            for (int i = 0; i < 8; i++) begin
                regs_d[i] = 8'h00;
            end
        end else if (wr_en_i) begin
            regs_d[wr_addr_i] = wr_data_i;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register bank storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Scan sequencer. A step blocked by Hold at terminal count still wraps the
    // prescaler, so after resume a full period elapses before Sel moves; the
    // resume edge itself already counts.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            estado_q <= PARADO;
            presc_q  <= '0;
            sel_q    <= 3'd0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            wrap_q <= 1'b0;
            if (!scan_en_i) begin
                estado_q <= PARADO;
                presc_q  <= '0;
                sel_q    <= 3'd0;
                busy_q   <= 1'b0;
            end else begin
                case (estado_q)
                    PARADO: begin
                        estado_q <= VARRENDO;
                        presc_q  <= '0;
                        sel_q    <= 3'd0;
                        busy_q   <= 1'b1;
                    end
                    VARRENDO, PAUSADO: begin
                        busy_q <= 1'b1;
                        if (hold_i) begin
                            estado_q <= PAUSADO;
                            if (presc_q == TC) begin
                                presc_q <= '0;
                            end else begin
                                presc_q <= presc_q;
                            end
                        end else begin
                            estado_q <= VARRENDO;
                            if (presc_q == TC) begin
                                presc_q <= '0;
                                sel_q   <= sel_q + 3'd1;
                                step_q  <= 1'b1;
                                wrap_q  <= (sel_q == 3'd7);
                            end else begin
                                presc_q <= presc_q + PW'(1'b1);
                            end
                        end
                    end
                    default: begin
                        estado_q <= PARADO;
                        presc_q  <= '0;
                        sel_q    <= 3'd0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign d0_o   = regs_q[0];
    assign d1_o   = regs_q[1];
    assign d2_o   = regs_q[2];
    assign d3_o   = regs_q[3];
    assign d4_o   = regs_q[4];
    assign d5_o   = regs_q[5];
    assign d6_o   = regs_q[6];
    assign d7_o   = regs_q[7];
    assign sel_o  = sel_q;
    assign step_o = step_q;
    assign wrap_o = wrap_q;
    assign busy_o = busy_q;

endmodule

// File: tb/tb_banco_registradores_varredura.sv
// Bench for banco_registradores_varredura: two instances (PRESCALE 4 and 1) against
// an abstract model, plus hand-computed expectations for the key scenarios.
module tb_banco_registradores_varredura;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       scan_en = 1'b0;
    logic       hold = 1'b0;
    logic       clr = 1'b0;

    logic [7:0] dw [2][8];
    logic [2:0] sel_w [2];
    logic       step_w [2];
    logic       wrap_w [2];
    logic       busy_w [2];

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;

    // model state
    int         m_p [2] = '{4, 1};
    bit         m_scan [2];
    int         m_ticks [2];
    int         m_sel [2];
    bit         m_step [2];
    bit         m_wrap [2];
    logic [7:0] m_regs [8];

    always #5 clk = ~clk;

    banco_registradores_varredura #(.PRESCALE(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .scan_en_i(scan_en), .hold_i(hold),
`ifdef BANCO_CLR_EN
        .clr_i(clr),
`endif
        .d0_o(dw[0][0]), .d1_o(dw[0][1]), .d2_o(dw[0][2]), .d3_o(dw[0][3]),
        .d4_o(dw[0][4]), .d5_o(dw[0][5]), .d6_o(dw[0][6]), .d7_o(dw[0][7]),
        .sel_o(sel_w[0]), .step_o(step_w[0]), .wrap_o(wrap_w[0]), .busy_o(busy_w[0])
    );

    banco_registradores_varredura #(.PRESCALE(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .scan_en_i(scan_en), .hold_i(hold),
`ifdef BANCO_CLR_EN
        .clr_i(clr),
`endif
        .d0_o(dw[1][0]), .d1_o(dw[1][1]), .d2_o(dw[1][2]), .d3_o(dw[1][3]),
        .d4_o(dw[1][4]), .d5_o(dw[1][5]), .d6_o(dw[1][6]), .d7_o(dw[1][7]),
        .sel_o(sel_w[1]), .step_o(step_w[1]), .wrap_o(wrap_w[1]), .busy_o(busy_w[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Model: each scanning edge either holds, or counts one tick; every P ticks Sel moves.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int u = 0; u < 2; u++) begin
                    m_scan[u] = 1'b0; m_ticks[u] = 0; m_sel[u] = 0;
                    m_step[u] = 1'b0; m_wrap[u] = 1'b0;
                end
                for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
            end else begin
                for (int u = 0; u < 2; u++) begin
                    m_step[u] = 1'b0;
                    m_wrap[u] = 1'b0;
                    if (!scan_en) begin
                        m_scan[u] = 1'b0; m_ticks[u] = 0; m_sel[u] = 0;
                    end else if (!m_scan[u]) begin
                        m_scan[u] = 1'b1; m_ticks[u] = 0;
                    end else if (hold) begin
                        if (m_ticks[u] == m_p[u] - 1) m_ticks[u] = 0;
                    end else begin
                        m_ticks[u] = m_ticks[u] + 1;
                        if (m_ticks[u] == m_p[u]) begin
                            m_ticks[u] = 0;
                            m_sel[u] = (m_sel[u] + 1) % 8;
                            m_step[u] = 1'b1;
                            m_wrap[u] = (m_sel[u] == 0);
                        end
                    end
                end
                if (clr) begin
                    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
                end else if (wr_en) begin
                    m_regs[wr_addr] = wr_data;
                end
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int u = 0; u < 2; u++) begin
                    chk($sformatf("u%0d_sel", u), sel_w[u], m_sel[u]);
                    chk($sformatf("u%0d_step", u), step_w[u], m_step[u]);
                    chk($sformatf("u%0d_wrap", u), wrap_w[u], m_wrap[u]);
                    chk($sformatf("u%0d_busy", u), busy_w[u], m_scan[u]);
                    for (int i = 0; i < 8; i++)
                        chk($sformatf("u%0d_d%0d", u, i), dw[u][i], m_regs[i]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        cycles(2);
        chk("rst_sel", sel_w[0], 0);
        chk("rst_busy", busy_w[0], 0);
        chk("rst_step", step_w[0], 0);
        chk("rst_d7", dw[0][7], 8'h00);
        cmp_en = 1'b1;

        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
        cycles(1);
        wr_en = 1'b0;
        chk("wr_d3", dw[0][3], 8'hA5);
        chk("wr_d2", dw[0][2], 8'h00);

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'((i + 1) * 17);
            cycles(1);
        end
        wr_en = 1'b0;
        chk("load_d7", dw[0][7], 8'h88);

        // scan: entry edge, then 32 edges of a full sweep
        scan_en = 1'b1;
        cycles(1);
        chk("entry_busy", busy_w[0], 1);
        chk("entry_sel", sel_w[0], 0);
        for (int k = 1; k <= 32; k++) begin
            cycles(1);
            chk($sformatf("p4_sel_k%0d", k), sel_w[0], (k / 4) % 8);
            chk($sformatf("p4_step_k%0d", k), step_w[0], (k % 4) == 0);
            chk($sformatf("p4_wrap_k%0d", k), wrap_w[0], k == 32);
            chk($sformatf("p1_sel_k%0d", k), sel_w[1], k % 8);
            chk($sformatf("p1_step_k%0d", k), step_w[1], 1);
            chk($sformatf("p1_wrap_k%0d", k), wrap_w[1], (k % 8) == 0);
        end

        // Hold on the 2->3 terminal count (edge 44), kept for 5 edges
        cycles(11);
        chk("pre_hold_sel", sel_w[0], 2);
        hold = 1'b1;
        cycles(5);
        chk("hold_sel", sel_w[0], 2);
        chk("hold_step", step_w[0], 0);
        hold = 1'b0;
        cycles(3);
        chk("resume3_sel", sel_w[0], 2);
        cycles(1);
        chk("resume4_sel", sel_w[0], 3);
        chk("resume4_step", step_w[0], 1);

        // Stop while paused at Sel=5
        cycles(8);
        chk("pre_stop_sel", sel_w[0], 5);
        hold = 1'b1;
        cycles(2);
        chk("paused_sel", sel_w[0], 5);
        chk("paused_busy", busy_w[0], 1);
        scan_en = 1'b0;
        cycles(1);
        chk("stop_sel", sel_w[0], 0);
        chk("stop_busy", busy_w[0], 0);
        chk("stop_step", step_w[0], 0);
        chk("stop_wrap", wrap_w[0], 0);
        hold = 1'b0;

        // Reset mid-scan with a write pending
        scan_en = 1'b1;
        cycles(10);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'h3C;
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_sel", sel_w[0], 0);
        chk("midrst_busy", busy_w[0], 0);
        chk("midrst_d5", dw[0][5], 8'h00);
        cycles(1);
        rst = 1'b0;
        wr_en = 1'b0;
        cycles(1);
        chk("postrst_d5", dw[0][5], 8'h00);
        chk("postrst_d3", dw[0][3], 8'h00);
        cycles(6);

`ifdef BANCO_CLR_EN
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'((i + 1) * 17);
            cycles(1);
        end
        chk("clr_pre_d4", dw[0][4], 8'h55);
        clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
        cycles(1);
        clr = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < 8; i++) chk($sformatf("clr_d%0d", i), dw[0][i], 8'h00);
        cycles(8);
`endif

        scan_en = 1'b0;
        cycles(2);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
